// File: rtl/sigmag_thr_sched.sv
// Round-robin bisection engine that calibrates one |x| threshold per ADC channel.
// Define SIGMAG_THR_SCHED_SKIP_EN to add a per-channel skip input.
module sigmag_thr_sched #(
    parameter int WIDTH      = 14,
    parameter int NCH        = 4,
    parameter int CNTR_WIDTH = 14,
    parameter int TARGET     = 5461,
    localparam int CHW       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
`ifdef SIGMAG_THR_SCHED_SKIP_EN
    input  logic [NCH-1:0]             skip,
`endif
    input  logic [NCH*WIDTH-1:0]       data_in,
    input  logic                       start,
    input  logic                       cont,
    output logic [NCH*(WIDTH-1)-1:0]   thr_out,
    output logic [NCH-1:0]             thr_valid,
    output logic [CHW-1:0]             ch_sel,
    output logic                       busy,
    output logic                       done
);

    localparam int TW = WIDTH - 1;
    localparam int IW = $clog2(WIDTH);
    localparam logic [TW-1:0]         THR_RST   = {1'b0, {(WIDTH-2){1'b1}}};
    localparam logic [TW-1:0]         HI_INIT   = '1;
    localparam logic [IW-1:0]         ITER_LAST = IW'(WIDTH - 2);
    localparam logic [CHW-1:0]        CH_LAST   = CHW'(NCH - 1);
    localparam logic [CNTR_WIDTH:0]   TARGET_C  = (CNTR_WIDTH+1)'(TARGET);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_WINDOW, S_DRAIN, S_UPDATE, S_STORE, S_NEXT
    } state_t;

    state_t                r_state;
    logic [CHW-1:0]        r_ch;
    logic [TW-1:0]         r_lo;
    logic [TW-1:0]         r_hi;
    logic [TW-1:0]         r_thr;
    logic [IW-1:0]         r_iter;
    logic [CNTR_WIDTH-1:0] r_win_cnt;
    logic [CNTR_WIDTH:0]   r_hit_cnt;
    logic                  r_hit;
    logic [TW-1:0]         r_thr_out [NCH];
    logic [NCH-1:0]        r_thr_valid;
    logic                  r_busy;
    logic                  r_done;

    logic signed [WIDTH-1:0] w_samp [NCH];
    logic signed [WIDTH-1:0] w_x;
    logic signed [WIDTH:0]   w_x_ext;
    logic signed [WIDTH:0]   w_thr_pos;
    logic signed [WIDTH:0]   w_thr_neg;
    logic                    w_hit;
    logic [TW-1:0]           w_mid;
    logic                    w_skip;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        assign w_samp[g]            = data_in[g*WIDTH +: WIDTH];
        assign thr_out[g*TW +: TW]  = r_thr_out[g];
    end

    // Magnitude test done in WIDTH+1 signed bits so -thr and the most negative sample both fit.
    assign w_x       = w_samp[r_ch];
    assign w_x_ext   = {w_x[WIDTH-1], w_x};
    assign w_thr_pos = {2'b00, r_thr};
    assign w_thr_neg = -w_thr_pos;
    assign w_hit     = (w_x_ext > w_thr_pos) || (w_x_ext < w_thr_neg);
    assign w_mid     = TW'((WIDTH'(r_lo) + WIDTH'(r_hi)) >> 1);

`ifdef SIGMAG_THR_SCHED_SKIP_EN
    assign w_skip = (r_iter == '0) && skip[r_ch];
`else
    assign w_skip = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_ch        <= '0;
            r_lo        <= '0;
            r_hi        <= '0;
            r_thr       <= '0;
            r_iter      <= '0;
            r_win_cnt   <= '0;
            r_hit_cnt   <= '0;
            r_hit       <= 1'b0;
            r_thr_valid <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            // NOTE: the threshold array is a handful of live output registers, not RAM, so it is reset.
            for (int k = 0; k < NCH; k++) begin
                r_thr_out[k] <= THR_RST;
            end
        end else begin
            // NOTE: all state updates use <= so every branch reads pre-edge values.
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_ch    <= '0;
                        r_lo    <= '0;
                        r_hi    <= HI_INIT;
                        r_iter  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_thr     <= w_mid;
                    r_win_cnt <= '0;
                    r_hit_cnt <= '0;
                    r_hit     <= 1'b0;
                    r_state   <= w_skip ? S_NEXT : S_WINDOW;
                end
                S_WINDOW: begin
                    r_hit     <= w_hit;
                    r_hit_cnt <= r_hit_cnt + (CNTR_WIDTH+1)'(r_hit);
                    r_win_cnt <= r_win_cnt + CNTR_WIDTH'(1);
                    if (&r_win_cnt) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    r_hit_cnt <= r_hit_cnt + (CNTR_WIDTH+1)'(r_hit);
                    r_state   <= S_UPDATE;
                end
                S_UPDATE: begin
                    if (r_hit_cnt > TARGET_C) begin
                        r_lo <= r_thr;
                    end else begin
                        r_hi <= r_thr;
                    end
                    if (r_iter == ITER_LAST) begin
                        r_state <= S_STORE;
                    end else begin
                        r_iter  <= r_iter + IW'(1);
                        r_state <= S_LOAD;
                    end
                end
                S_STORE: begin
                    r_thr_out[r_ch]   <= w_mid;
                    r_thr_valid[r_ch] <= 1'b1;
                    r_state           <= S_NEXT;
                end
                S_NEXT: begin
                    r_lo   <= '0;
                    r_hi   <= HI_INIT;
                    r_iter <= '0;
                    if (r_ch < CH_LAST) begin
                        r_ch    <= r_ch + CHW'(1);
                        r_state <= S_LOAD;
                    end else begin
                        r_ch   <= '0;
                        r_done <= 1'b1;
                        if (cont) begin
                            r_state <= S_LOAD;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign thr_valid = r_thr_valid;
    assign ch_sel    = r_ch;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_sigmag_thr_sched.sv
// Self-checking bench for sigmag_thr_sched: constant-level vector table, random
// sample streams against a bisection model, plus continuous, reset and skip sequences.
module tb_sigmag_thr_sched;

    localparam int W       = 6;
    localparam int NCH     = 2;
    localparam int CW      = 4;
    localparam int TGT     = 5;
    localparam int TW      = W - 1;
    localparam int ITER    = 2**CW + 3;
    localparam int CHAN    = (W - 1) * ITER + 2;
    localparam int SWEEP   = NCH * CHAN;
    localparam int MAXC    = 512;
    localparam int THR_RST = 2**(W-2) - 1;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic                cont;
    logic [NCH*W-1:0]    data_in;
    logic [NCH*TW-1:0]   thr_out;
    logic [NCH-1:0]      thr_valid;
    logic [0:0]          ch_sel;
    logic                busy;
    logic                done;
`ifdef SIGMAG_THR_SCHED_SKIP_EN
    logic [NCH-1:0]      skip;
`endif

    sigmag_thr_sched #(.WIDTH(W), .NCH(NCH), .CNTR_WIDTH(CW), .TARGET(TGT)) u_dut (
        .clk       (clk),
        .reset     (reset),
`ifdef SIGMAG_THR_SCHED_SKIP_EN
        .skip      (skip),
`endif
        .data_in   (data_in),
        .start     (start),
        .cont      (cont),
        .thr_out   (thr_out),
        .thr_valid (thr_valid),
        .ch_sel    (ch_sel),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int              n_checks = 0;
    int              n_fail   = 0;
    int              cyc;
    bit              rnd_mode;
    int              hold_v [NCH];
    int              exp_thr [NCH];
    bit [NCH-1:0]    exp_valid;
    int              samp [NCH][MAXC];
    bit              start_mark [MAXC];
    logic            dn_log [MAXC];
    logic            bs_log [MAXC];
    logic [NCH-1:0]  vl_log [MAXC];
    logic [0:0]      cs_log [MAXC];
    logic [TW-1:0]   th_log [NCH][MAXC];

    typedef struct {
        int v0;
        int v1;
        int extra_start;
        int e0;
        int e1;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_cycle();
        for (int k = 0; k < NCH; k++) begin
            int v;
            v = rnd_mode ? (int'($urandom_range(63)) - 32) : hold_v[k];
            samp[k][cyc] = v;
            data_in[k*W +: W] = v[W-1:0];
        end
        start = start_mark[cyc];
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (cyc >= MAXC) begin
            $display("FAIL cycle_log: got %0d expected below %0d", cyc, MAXC);
            $fatal(1, "cycle log overflow");
        end
        dn_log[cyc] = done;
        bs_log[cyc] = busy;
        vl_log[cyc] = thr_valid;
        cs_log[cyc] = ch_sel;
        for (int k = 0; k < NCH; k++) th_log[k][cyc] = thr_out[k*TW +: TW];
    endtask

    task automatic run(input int n);
        repeat (n) begin
            drive_cycle();
            step();
        end
    endtask

    task automatic begin_sweep(input bit with_start);
        cyc = 0;
        for (int c = 0; c < MAXC; c++) start_mark[c] = 1'b0;
        start_mark[0] = with_start;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < NCH; k++) exp_thr[k] = THR_RST;
        exp_valid = '0;
    endtask

    // Bisection straight from the rules: the window of iteration i follows its LOAD cycle.
    function automatic int model_thr(input int ch, input int load0);
        int lo = 0;
        int hi = 2**(W-1) - 1;
        for (int it = 0; it < W - 1; it++) begin
            int thr;
            int hits;
            thr  = (lo + hi) / 2;
            hits = 0;
            for (int j = 1; j <= 2**CW; j++) begin
                int x;
                x = samp[ch][load0 + it*ITER + j];
                if (x > thr || x < -thr) hits++;
            end
            if (hits > TGT) lo = thr;
            else            hi = thr;
        end
        return (lo + hi) / 2;
    endfunction

    function automatic int count_done(input int from, input int to);
        int n = 0;
        for (int c = from; c <= to; c++) if (dn_log[c] === 1'b1) n++;
        return n;
    endfunction

    task automatic check_sweep(input string tag, input int s, input bit busy_end);
        int d;
        for (int k = 0; k < NCH; k++) begin
            int t;
            int m;
            t = s + k*CHAN + CHAN - 1;
            m = model_thr(k, s + k*CHAN);
            check($sformatf("%s_thr%0d_hold", tag, k), th_log[k][t-1], exp_thr[k]);
            check($sformatf("%s_thr%0d", tag, k), th_log[k][t], m);
            check($sformatf("%s_valid%0d_pre", tag, k), vl_log[t-1][k], exp_valid[k]);
            check($sformatf("%s_valid%0d", tag, k), vl_log[t][k], 1);
            exp_thr[k]   = m;
            exp_valid[k] = 1'b1;
        end
        d = s + SWEEP;
        check({tag, "_chsel_ch0"}, cs_log[s + CHAN - 1], 0);
        check({tag, "_chsel_ch1"}, cs_log[s + CHAN], 1);
        check({tag, "_done_pre"}, dn_log[d-1], 0);
        check({tag, "_done"}, dn_log[d], 1);
        check({tag, "_done_post"}, dn_log[d+1], 0);
        check({tag, "_busy_end"}, bs_log[d], busy_end);
    endtask

    initial begin
        vec_t vecs [6];
        vecs[0] = '{v0: 20,  v1: -3,  extra_start: 0,  e0: 19, e1: 2};
        vecs[1] = '{v0: 20,  v1: -3,  extra_start: 50, e0: 19, e1: 2};
        vecs[2] = '{v0: 0,   v1: 0,   extra_start: 0,  e0: 0,  e1: 0};
        vecs[3] = '{v0: 31,  v1: -32, extra_start: 0,  e0: 30, e1: 30};
        vecs[4] = '{v0: 16,  v1: -1,  extra_start: 0,  e0: 15, e1: 0};
        vecs[5] = '{v0: 5,   v1: -20, extra_start: 0,  e0: 4,  e1: 19};

        reset    = 1'b1;
        start    = 1'b0;
        cont     = 1'b0;
        data_in  = '0;
        rnd_mode = 1'b0;
`ifdef SIGMAG_THR_SCHED_SKIP_EN
        skip     = '0;
`endif
        #1;
        check("rst_thr0", thr_out[0 +: TW], THR_RST);
        check("rst_thr1", thr_out[TW +: TW], THR_RST);
        check("rst_valid", thr_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_chsel", ch_sel, 0);
        @(negedge clk);
        do_reset();

        // Constant-level vectors; entry 1 adds an ignored start pulse mid-sweep.
        for (int i = 0; i < 6; i++) begin
            hold_v[0] = vecs[i].v0;
            hold_v[1] = vecs[i].v1;
            begin_sweep(1'b1);
            if (vecs[i].extra_start != 0) start_mark[vecs[i].extra_start] = 1'b1;
            run(SWEEP + 3);
            check_sweep($sformatf("vec%0d", i), 1, 1'b0);
            check($sformatf("vec%0d_tab0", i), th_log[0][SWEEP+2], vecs[i].e0);
            check($sformatf("vec%0d_tab1", i), th_log[1][SWEEP+2], vecs[i].e1);
            check($sformatf("vec%0d_ndone", i), count_done(1, SWEEP + 3), 1);
            check($sformatf("vec%0d_idle", i), bs_log[SWEEP+3], 0);
        end

        // Random per-cycle samples against the bisection model.
        rnd_mode = 1'b1;
        for (int r = 0; r < 4; r++) begin
            begin_sweep(1'b1);
            run(SWEEP + 3);
            check_sweep($sformatf("rnd%0d", r), 1, 1'b0);
        end
        rnd_mode = 1'b0;

        // Continuous mode: second sweep sees ch0 at +5, cont drops during it.
        hold_v[0] = 20;
        hold_v[1] = -3;
        cont = 1'b1;
        begin_sweep(1'b1);
        run(SWEEP);
        hold_v[0] = 5;
        run(300 - SWEEP);
        cont = 1'b0;
        run(2*SWEEP + 3 - 300);
        check_sweep("cont1", 1, 1'b1);
        check_sweep("cont2", SWEEP + 1, 1'b0);
        check("cont_thr0_new", th_log[0][SWEEP + CHAN], 4);
        check("cont_ndone", count_done(1, 2*SWEEP + 3), 2);
        check("cont_idle", bs_log[2*SWEEP + 3], 0);

        // Reset in the middle of channel 1.
        hold_v[0] = 20;
        hold_v[1] = -3;
        begin_sweep(1'b1);
        run(120);
        check("mid_valid0_set", vl_log[120][0], 1);
        reset = 1'b1;
        #1;
        check("mid_rst_thr0", thr_out[0 +: TW], THR_RST);
        check("mid_rst_thr1", thr_out[TW +: TW], THR_RST);
        check("mid_rst_valid", thr_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        @(negedge clk);
        do_reset();
        begin_sweep(1'b0);
        run(5);
        check("mid_rst_stays_idle", bs_log[5], 0);
        begin_sweep(1'b1);
        run(SWEEP + 3);
        check_sweep("rerun", 1, 1'b0);
        check("rerun_thr0", th_log[0][SWEEP+2], 19);
        check("rerun_thr1", th_log[1][SWEEP+2], 2);

`ifdef SIGMAG_THR_SCHED_SKIP_EN
        do_reset();
        skip = 2'b01;
        begin_sweep(1'b1);
        run(105);
        check("skip_valid0", vl_log[104][0], 0);
        check("skip_thr0", th_log[0][104], THR_RST);
        check("skip_thr1_hold", th_log[1][98], THR_RST);
        check("skip_thr1", th_log[1][99], model_thr(1, 3));
        check("skip_thr1_tab", th_log[1][99], 2);
        check("skip_done_pre", dn_log[99], 0);
        check("skip_done", dn_log[100], 1);
        check("skip_busy", bs_log[100], 0);
        check("skip_ndone", count_done(1, 105), 1);
        skip = '0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
